clock_enable_generator: RTL and testbench

Parametrised, single-clock successor of the core clock control path. It generates per-channel clock-enable pulses instead of gated clocks, serving several cores or peripherals. It supports run, slow (power-of-two divided) and manual single-step modes, with per-channel stall and per-channel tick counters. Button inputs are synchronised and debounced in the block, which sits between the board buttons and every `core_clock`-domain consumer.

---
 rtl/clock_enable_generator.sv | 172 +++++++++++++++++
 tb/tb_clock_enable_generator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_enable_generator.sv
// Per-channel clock-enable pulses with RUN / SLOW / MANUAL modes, debounced buttons, tick and ms counters.
// Enables are registered pulses masked combinationally by stall; no backpressure beyond per-channel stall.
module clock_enable_generator #(
    parameter int CHANNELS        = 2,
    parameter int DIVISOR_WIDTH   = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_WIDTH      = 64,
    parameter int MS_PRESCALE     = 100000
) (
    input  logic                              clock_100mhz,
    input  logic                              reset,
    input  logic                              frequency_mode_button,
    input  logic                              clock_mode_button,
    input  logic                              manual_clock_button,
    input  logic [CHANNELS*DIVISOR_WIDTH-1:0] clock_divisor,
    input  logic [CHANNELS-1:0]               stall_core,
    output logic [CHANNELS-1:0]               core_clock_enable,
    output logic                              clock_manual_mode,
    output logic                              clock_slow_mode,
    output logic [CHANNELS*TICK_WIDTH-1:0]    core_clock_ticks,
    output logic [TICK_WIDTH-1:0]             miliseconds
);

    localparam int PRESCALE_WIDTH = 2**DIVISOR_WIDTH - 1;
    localparam int DB_WIDTH = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int MS_WIDTH = (MS_PRESCALE > 1) ? $clog2(MS_PRESCALE) : 1;
    localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [MS_WIDTH-1:0] MS_LAST = MS_WIDTH'(MS_PRESCALE - 1);
    localparam int BTN_FREQ = 0;
    localparam int BTN_MODE = 1;
    localparam int BTN_STEP = 2;

    // Encoding is {manual, auto_slow} so the outputs are the state bits.
    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SLOW     = 2'b01,
        MODE_MAN_RUN  = 2'b10,
        MODE_MAN_SLOW = 2'b11
    } mode_t;

    logic [2:0]                btn_raw;
    logic [2:0]                btn_meta;
    logic [2:0]                btn_sync;
    logic [2:0]                btn_level;
    logic [2:0]                btn_press;
    logic [DB_WIDTH-1:0]       db_cnt [3];
    mode_t                     mode;
    logic [PRESCALE_WIDTH-1:0] prescaler;
    logic                      running;
    logic [CHANNELS-1:0]       base;
    logic [CHANNELS-1:0]       pending;
    logic [TICK_WIDTH-1:0]     ticks [CHANNELS];
    logic [MS_WIDTH-1:0]       ms_cnt;

    assign btn_raw = {manual_clock_button, clock_mode_button, frequency_mode_button};

    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            btn_meta  <= '0;
            btn_sync  <= '0;
            btn_level <= '0;
            btn_press <= '0;
            for (int b = 0; b < 3; b++) db_cnt[b] <= '0;
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
            for (int b = 0; b < 3; b++) begin
                btn_press[b] <= 1'b0;
                if (btn_sync[b] == btn_level[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_LAST) begin
                    db_cnt[b]    <= '0;
                    btn_level[b] <= btn_sync[b];
                    btn_press[b] <= btn_sync[b];
                end else begin
                    db_cnt[b] <= db_cnt[b] + 1'b1;
                end
            end
        end
    end

    // Clock-mode press wins over a same-cycle frequency press; prescaler restarts on SLOW entry.
    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            mode      <= MODE_RUN;
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
            case (mode)
                MODE_RUN: begin
                    if (btn_press[BTN_MODE]) begin
                        mode <= MODE_MAN_RUN;
                    end else if (btn_press[BTN_FREQ]) begin
                        mode      <= MODE_SLOW;
                        prescaler <= '0;
                    end
                end
                MODE_SLOW: begin
                    if (btn_press[BTN_MODE])      mode <= MODE_MAN_SLOW;
                    else if (btn_press[BTN_FREQ]) mode <= MODE_RUN;
                end
                MODE_MAN_RUN: begin
                    if (btn_press[BTN_MODE]) mode <= MODE_RUN;
                end
                default: begin
                    if (btn_press[BTN_MODE]) begin
                        mode      <= MODE_SLOW;
                        prescaler <= '0;
                    end
                end
            endcase
        end
    end

    assign clock_manual_mode = mode[1];
    assign clock_slow_mode   = mode[0];

    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            running <= 1'b0;
            base    <= '0;
            pending <= '0;
        end else begin
            running <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                case (mode)
                    MODE_RUN: begin
                        base[i]    <= running;
                        pending[i] <= 1'b0;
                    end
                    MODE_SLOW: begin
                        // Bits at or above d_i are forced high, so only the low d_i bits must be ones.
                        base[i]    <= &(prescaler | ({PRESCALE_WIDTH{1'b1}} <<
                                        clock_divisor[i*DIVISOR_WIDTH +: DIVISOR_WIDTH]));
                        pending[i] <= 1'b0;
                    end
                    default: begin
                        base[i] <= pending[i] & ~stall_core[i];
                        if (btn_press[BTN_MODE]) pending[i] <= 1'b0;
                        else if (pending[i])     pending[i] <= stall_core[i];
                        else                     pending[i] <= btn_press[BTN_STEP];
                    end
                endcase
            end
        end
    end

    assign core_clock_enable = base & ~stall_core;

    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) ticks[i] <= '0;
            ms_cnt      <= '0;
            miliseconds <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (core_clock_enable[i]) ticks[i] <= ticks[i] + 1'b1;
            end
            if (ms_cnt == MS_LAST) begin
                ms_cnt      <= '0;
                miliseconds <= miliseconds + 1'b1;
            end else begin
                ms_cnt <= ms_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ticks
        assign core_clock_ticks[g*TICK_WIDTH +: TICK_WIDTH] = ticks[g];
    end

endmodule

// File: tb/tb_clock_enable_generator.sv
// Directed bench: main instance with short debounce/ms prescale, second instance with 4-bit counters for wrap.
module tb_clock_enable_generator;

    logic         clk = 1'b0;
    logic         reset;
    logic         reset2;
    logic         freq_btn;
    logic         mode_btn;
    logic         step_btn;
    logic [9:0]   divisor;
    logic [1:0]   stall;
    logic [1:0]   en;
    logic         man;
    logic         slow;
    logic [127:0] ticks;
    logic [63:0]  ms;
    logic [1:0]   en2;
    logic         man2;
    logic         slow2;
    logic [7:0]   ticks2;
    logic [3:0]   ms2;

    int compared   = 0;
    int mismatched = 0;
    int cnt0       = 0;
    int cnt1       = 0;
    logic [15:0] pos0;
    logic [15:0] pos1;
    logic [7:0]  pos2;

    always #5 clk = ~clk;

    clock_enable_generator #(
        .CHANNELS(2), .DIVISOR_WIDTH(5), .DEBOUNCE_CYCLES(4), .TICK_WIDTH(64), .MS_PRESCALE(10)
    ) dut (
        .clock_100mhz(clk),
        .reset(reset),
        .frequency_mode_button(freq_btn),
        .clock_mode_button(mode_btn),
        .manual_clock_button(step_btn),
        .clock_divisor(divisor),
        .stall_core(stall),
        .core_clock_enable(en),
        .clock_manual_mode(man),
        .clock_slow_mode(slow),
        .core_clock_ticks(ticks),
        .miliseconds(ms)
    );

    clock_enable_generator #(
        .CHANNELS(2), .DIVISOR_WIDTH(5), .DEBOUNCE_CYCLES(4), .TICK_WIDTH(4), .MS_PRESCALE(10)
    ) dut_wrap (
        .clock_100mhz(clk),
        .reset(reset2),
        .frequency_mode_button(1'b0),
        .clock_mode_button(1'b0),
        .manual_clock_button(1'b0),
        .clock_divisor(10'd0),
        .stall_core(2'b00),
        .core_clock_enable(en2),
        .clock_manual_mode(man2),
        .clock_slow_mode(slow2),
        .core_clock_ticks(ticks2),
        .miliseconds(ms2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; sample 1 time unit after each and accumulate enable pulses.
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cnt0 += int'(en[0]);
            cnt1 += int'(en[1]);
        end
    endtask

    task automatic press(input logic f, input logic m, input logic s);
        freq_btn = f;
        mode_btn = m;
        step_btn = s;
        cycles(10);
        freq_btn = 1'b0;
        mode_btn = 1'b0;
        step_btn = 1'b0;
        cycles(10);
    endtask

    initial begin
        reset    = 1'b1;
        reset2   = 1'b1;
        freq_btn = 1'b0;
        mode_btn = 1'b0;
        step_btn = 1'b0;
        divisor  = {5'd2, 5'd0};
        stall    = 2'b00;
        cycles(3);
        check("reset_en",    64'(en), 64'h0);
        check("reset_mode",  64'({man, slow}), 64'h0);
        check("reset_ticks", ticks[63:0] | ticks[127:64], 64'h0);
        check("reset_ms",    ms, 64'h0);

        // RUN: edge 1 after release still all zero, enables from edge 2.
        reset = 1'b0;
        cycles(1);
        check("release_en",    64'(en), 64'h0);
        check("release_ticks", ticks[63:0] | ticks[127:64], 64'h0);
        cycles(1);
        check("run_en", 64'(en), 64'h3);
        cycles(19);
        check("run_ticks0", ticks[63:0], 64'd19);
        check("run_ticks1", ticks[127:64], 64'd19);
        check("run_ms", ms, 64'd2);

        // Bounce 1-0-1 then hold: SLOW exactly 7 edges after the final rise.
        freq_btn = 1'b1;
        cycles(2);
        freq_btn = 1'b0;
        cycles(2);
        freq_btn = 1'b1;
        cycles(6);
        check("debounce_early", 64'(slow), 64'h0);
        cycles(1);
        check("debounce_slow", 64'({man, slow}), 64'h1);

        // SLOW with d0=0, d1=2: ch1 on every 4th cycle.
        for (int k = 0; k < 16; k++) begin
            cycles(1);
            pos0[k] = en[0];
            pos1[k] = en[1];
        end
        check("slow_ch0_pattern", 64'(pos0), 64'hFFFF);
        check("slow_ch1_pattern", 64'(pos1), 64'h8888);
        divisor[9:5] = 5'd1;
        for (int k = 0; k < 8; k++) begin
            cycles(1);
            pos2[k] = en[1];
        end
        check("slow_ch1_d1", 64'(pos2), 64'hAA);

        freq_btn = 1'b0;
        cycles(10);
        freq_btn = 1'b1;
        cycles(3);
        freq_btn = 1'b0;
        cycles(12);
        check("glitch_ignored", 64'({man, slow}), 64'h1);

        // MANUAL entered from SLOW keeps slow indication.
        press(1'b0, 1'b1, 1'b0);
        check("manual_from_slow", 64'({man, slow}), 64'h3);

        stall = 2'b10;
        cnt0 = 0;
        cnt1 = 0;
        press(1'b0, 1'b0, 1'b1);
        check("step_ch0", 64'(cnt0), 64'd1);
        check("step_ch1_stalled", 64'(cnt1), 64'd0);
        cnt0 = 0;
        cnt1 = 0;
        press(1'b0, 1'b0, 1'b1);
        check("step2_ch0", 64'(cnt0), 64'd1);
        check("step2_ch1_stalled", 64'(cnt1), 64'd0);
        stall = 2'b00;
        cnt0 = 0;
        cnt1 = 0;
        cycles(1);
        check("unstall_first", 64'(en), 64'h2);
        cycles(8);
        check("unstall_ch1_once", 64'(cnt1), 64'd1);
        check("unstall_ch0_none", 64'(cnt0), 64'd0);

        // Leave MANUAL with both channels pending, then return via simultaneous presses.
        stall = 2'b11;
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        check("leave_to_slow", 64'({man, slow}), 64'h1);
        press(1'b1, 1'b0, 1'b0);
        check("slow_to_run", 64'({man, slow}), 64'h0);
        press(1'b1, 1'b1, 1'b0);
        check("simultaneous", 64'({man, slow}), 64'h2);
        stall = 2'b00;
        cnt0 = 0;
        cnt1 = 0;
        cycles(10);
        check("pending_dropped", 64'(cnt0 + cnt1), 64'd0);
        press(1'b0, 1'b0, 1'b1);
        check("step_after_return", 64'(cnt0 + cnt1), 64'd2);

        // Reset while SLOW with a clock-mode press mid-debounce.
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check("pre_reset_slow", 64'({man, slow}), 64'h1);
        mode_btn = 1'b1;
        cycles(4);
        reset    = 1'b1;
        mode_btn = 1'b0;
        cycles(2);
        check("midreset_mode",  64'({man, slow}), 64'h0);
        check("midreset_ticks", ticks[63:0] | ticks[127:64], 64'h0);
        check("midreset_ms",    ms, 64'h0);
        reset = 1'b0;
        cycles(1);
        check("midreset_release_en", 64'(en), 64'h0);
        cycles(12);
        check("midreset_no_press", 64'({man, slow}), 64'h0);
        check("midreset_run_en", 64'(en), 64'h3);

        // 4-bit tick counters: 17 enables wrap to 1; 17 ms wrap to 1.
        reset2 = 1'b0;
        cycles(19);
        check("wrap_ticks", 64'(ticks2), 64'h11);
        cycles(151);
        check("wrap_ms", 64'(ms2), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
